// File: rtl/mpc_vsub_row_stream_pkg.sv
// Shared types and helpers for the row-subtract stream (e[i] - x[i]).
// Optional saturation is selected by MPC_VSUB_SAT_EN.
package mpc_vsub_pkg;

  typedef enum logic [1:0] {IDLE, PREF, RUN, FLUSH} vsub_state_e;

  localparam int VSUB_DW = 17;
  localparam logic [VSUB_DW-1:0] VSUB_MAX = {1'b0, {(VSUB_DW-1){1'b1}}};
  localparam logic [VSUB_DW-1:0] VSUB_MIN = {1'b1, {(VSUB_DW-1){1'b0}}};

  // A (W+1)-bit signed value fits W bits only when its top two bits agree.
  function automatic logic vsub_ovf(input logic sign_ext, input logic sign);
    return sign_ext != sign;
  endfunction

  function automatic logic [VSUB_DW-1:0] vsub_conv(input logic [VSUB_DW:0] d,
                                                   input logic sat_en);
    if (sat_en && vsub_ovf(d[VSUB_DW], d[VSUB_DW-1]))
      return d[VSUB_DW] ? VSUB_MIN : VSUB_MAX;
    return d[VSUB_DW-1:0];
  endfunction

endpackage

// File: rtl/mpc_vsub_row_stream_if.sv
// Element stream of the row-subtract block: x[i] in, r[i] out, valid/ready on both.
// master = the subtract block, slave = upstream/downstream neighbours.
interface mpc_vsub_row_stream_if #(
  parameter int DATA_WIDTH = 17
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

  modport slave (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/mpc_vsub_row_stream_sat.sv
// Combinational (DATA_WIDTH+1)->DATA_WIDTH narrowing; clamps when MPC_VSUB_SAT_EN
// is defined, otherwise keeps the low DATA_WIDTH bits (two's-complement wrap).
module mpc_vsub_sat
  import mpc_vsub_pkg::*;
#(
  parameter int DATA_WIDTH = 17
) (
  input  logic [DATA_WIDTH:0]   d,
  output logic [DATA_WIDTH-1:0] q
);

`ifdef MPC_VSUB_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  localparam logic [DATA_WIDTH-1:0] MAXV = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MINV = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  always_comb begin
    q = d[DATA_WIDTH-1:0];
    if (SAT_EN && vsub_ovf(d[DATA_WIDTH], d[DATA_WIDTH-1]))
      q = d[DATA_WIDTH] ? MINV : MAXV;
  end

endmodule

// File: rtl/mpc_vsub_row_stream.sv
// Streams one row, r[i] = e[i] - x[i] with e from a 1-read ROM; start->first out >= 3 cycles,
// then 1 element/cycle. Single output register: input stalls while out_valid && !out_ready.
module mpc_vsub_row_stream
  import mpc_vsub_pkg::*;
#(
  parameter int DATA_WIDTH = 17,
  parameter int ADDR_WIDTH = 3,
  parameter int VEC_LEN    = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_address0,
  output logic                  rom_ce0,
  input  logic [DATA_WIDTH-1:0] rom_q0,
  mpc_vsub_row_stream_if.master strm
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(VEC_LEN - 1);

  vsub_state_e           state;
  logic [ADDR_WIDTH-1:0] idx;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_valid_q;
  logic                  out_last_q;
  logic                  in_ready;
  logic                  hs;
  logic                  more;
  logic [DATA_WIDTH:0]   diff;
  logic [DATA_WIDTH-1:0] res;

  assign in_ready = (state == RUN) && (!out_valid_q || strm.out_ready);
  assign hs       = strm.in_valid && in_ready;
  assign more     = (idx != LAST);

  // ROM read is issued in the same cycle as the handshake so the next e[i]
  // is already registered in rom_q0 for a back-to-back handshake.
  assign rom_ce0      = !reset && (((state == IDLE) && start) || (hs && more));
  assign rom_address0 = (hs && more) ? idx + ADDR_WIDTH'(1) : '0;

  assign diff = {rom_q0[DATA_WIDTH-1], rom_q0} - {strm.in_data[DATA_WIDTH-1], strm.in_data};

  mpc_vsub_sat #(.DATA_WIDTH(DATA_WIDTH)) u_sat (
    .d (diff),
    .q (res)
  );

  assign strm.in_ready  = in_ready;
  assign strm.out_data  = out_data_q;
  assign strm.out_valid = out_valid_q;
  assign strm.out_last  = out_last_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            idx   <= '0;
            busy  <= 1'b1;
            state <= PREF;
          end
        end
        PREF: state <= RUN;
        RUN: begin
          if (hs) begin
            out_data_q  <= res;
            out_valid_q <= 1'b1;
            out_last_q  <= (idx == LAST);
            if (more) idx   <= idx + ADDR_WIDTH'(1);
            else      state <= FLUSH;
          end else if (out_valid_q && strm.out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
          end
        end
        FLUSH: begin
          if (out_valid_q && strm.out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpc_vsub_row_stream.sv
// Directed bench for mpc_vsub_row_stream: a VEC_LEN=6 instance plus a VEC_LEN=1 instance,
// each with its own ROM model; expected values are hand-computed constants.
module tb_mpc_vsub_row_stream;

  localparam logic [16:0] EA = 17'h08000;
  localparam logic [16:0] EB = 17'h19220;

  logic        clk = 1'b0;
  logic        reset, start, start1;
  logic        busy, done, rom_ce0;
  logic [2:0]  rom_address0;
  logic [16:0] rom_q0 = '0;
  logic        busy1, done1, rom_ce1;
  logic [2:0]  rom_addr1;
  logic [16:0] rom_q1 = '0;

  logic [16:0] rom  [8];
  logic [16:0] rom1 [8];
  logic [16:0] xv   [8];
  int          feed_idx;

  int          cyc = 0;
  int          n_chk = 0;
  int          n_err = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic        busy_at_done = 1'b0;
  logic [16:0] q_dat [$];
  logic        q_last [$];
  int          q_cyc [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mpc_vsub_row_stream_if #(.DATA_WIDTH(17)) s  ();
  mpc_vsub_row_stream_if #(.DATA_WIDTH(17)) s1 ();

  mpc_vsub_row_stream #(.DATA_WIDTH(17), .ADDR_WIDTH(3), .VEC_LEN(6)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .rom_address0 (rom_address0),
    .rom_ce0      (rom_ce0),
    .rom_q0       (rom_q0),
    .strm         (s.master)
  );

  mpc_vsub_row_stream #(.DATA_WIDTH(17), .ADDR_WIDTH(3), .VEC_LEN(1)) u_dut1 (
    .clk          (clk),
    .reset        (reset),
    .start        (start1),
    .busy         (busy1),
    .done         (done1),
    .rom_address0 (rom_addr1),
    .rom_ce0      (rom_ce1),
    .rom_q0       (rom_q1),
    .strm         (s1.master)
  );

  // ROM models: q0 registered on ce0, held otherwise.
  always @(posedge clk) if (rom_ce0) rom_q0 <= rom[rom_address0];
  always @(posedge clk) if (rom_ce1) rom_q1 <= rom1[rom_addr1];

  // Upstream: advance x on every accepted element.
  initial begin
    forever begin
      @(negedge clk);
      if (s.in_valid && s.in_ready) begin
        @(posedge clk);
        #1;
        if (feed_idx < 7) feed_idx++;
        s.in_data = xv[feed_idx];
      end
    end
  end

  // Downstream: record every accepted output and every done pulse.
  always @(negedge clk) begin
    if (s.out_valid && s.out_ready) begin
      q_dat.push_back(s.out_data);
      q_last.push_back(s.out_last);
      q_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc     = cyc;
      busy_at_done = busy;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic clear_mon;
    q_dat.delete();
    q_last.delete();
    q_cyc.delete();
  endtask

  task automatic set_x(input logic [16:0] x0, input logic [16:0] x1, input logic [16:0] inc);
    xv[0] = x0;
    xv[1] = x1;
    for (int i = 2; i < 8; i++) xv[i] = (inc != 0) ? 17'(i + 1) : 17'h0;
    feed_idx  = 0;
    s.in_data = xv[0];
  endtask

  task automatic wait_done(input int budget, input int cnt0);
    for (int i = 0; i < budget && done_cnt == cnt0; i++) step();
    chk("row_done", done_cnt, cnt0 + 1);
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_busy"},     busy,          0);
    chk({p, "_done"},     done,          0);
    chk({p, "_rom_ce0"},  rom_ce0,       0);
    chk({p, "_rom_addr"}, rom_address0,  0);
    chk({p, "_in_ready"}, s.in_ready,    0);
    chk({p, "_out_vld"},  s.out_valid,   0);
    chk({p, "_out_last"}, s.out_last,    0);
    chk({p, "_out_dat"},  s.out_data,    0);
  endtask

  task automatic chk_row_alt(input string p);
    chk({p, "_cnt"}, q_dat.size(), 6);
    for (int i = 0; i < q_dat.size() && i < 6; i++) begin
      chk($sformatf("%s_dat%0d", p, i), q_dat[i], (i % 2) ? EB : EA);
      chk($sformatf("%s_last%0d", p, i), q_last[i], (i == 5) ? 1 : 0);
    end
  endtask

  logic [16:0] e3 [6];
  int          c0, d0;

  initial begin
    e3 = '{17'h07FFF, 17'h1921E, 17'h07FFD, 17'h1921C, 17'h07FFB, 17'h1921A};
    reset = 1'b1; start = 1'b0; start1 = 1'b0;
    s.in_valid = 1'b0; s.out_ready = 1'b0;
    s1.in_valid = 1'b0; s1.in_data = '0; s1.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rom[i]  = (i % 2) ? EB : EA;
      rom1[i] = 17'h0;
    end
    rom1[0] = EA;
    set_x(17'h0, 17'h0, 17'h0);
    repeat (3) step();
    chk_reset("init");
    chk("init_busy1", busy1, 0);
    reset = 1'b0;
    step();

    // Alternating ROM, x = 0, full-rate stream.
    clear_mon();
    s.in_valid = 1'b1; s.out_ready = 1'b1;
    c0 = cyc; d0 = done_cnt;
    pulse_start();
    wait_done(40, d0);
    chk_row_alt("t1");
    if (q_cyc.size() == 6) begin
      chk("t1_lat_ge3",   (q_cyc[0] - c0) >= 3, 1);
      chk("t1_gap",       q_cyc[5] - q_cyc[0], 5);
      chk("t1_done_lat",  done_cyc - q_cyc[5], 1);
    end
    chk("t1_busy_at_done", busy_at_done, 0);
    s.in_valid = 1'b0;
    step();

    // Overflow corners.
    clear_mon();
    set_x(17'h10000, 17'h0FFFF, 17'h0);
    s.in_valid = 1'b1;
    d0 = done_cnt;
    pulse_start();
    wait_done(40, d0);
    chk("t2_cnt", q_dat.size(), 6);
    if (q_dat.size() >= 2) begin
`ifdef MPC_VSUB_SAT_EN
      chk("t2_pos_ovf", q_dat[0], 17'h0FFFF);
      chk("t2_neg_ovf", q_dat[1], 17'h10000);
`else
      chk("t2_pos_ovf", q_dat[0], 17'h18000);
      chk("t2_neg_ovf", q_dat[1], 17'h09221);
`endif
    end
    s.in_valid = 1'b0;
    step();

    // Downstream stall of 5 cycles on the first output.
    clear_mon();
    set_x(17'h1, 17'h2, 17'h1);
    s.in_valid = 1'b1; s.out_ready = 1'b0;
    d0 = done_cnt;
    pulse_start();
    for (int i = 0; i < 20 && !s.out_valid; i++) step();
    chk("t3_first_vld", s.out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3_hold_dat%0d", i), s.out_data, 17'h07FFF);
      chk($sformatf("t3_hold_vld%0d", i), s.out_valid, 1);
      chk($sformatf("t3_hold_rdy%0d", i), s.in_ready, 0);
      chk($sformatf("t3_hold_ce%0d", i),  rom_ce0, 0);
      step();
    end
    s.out_ready = 1'b1;
    wait_done(40, d0);
    chk("t3_cnt", q_dat.size(), 6);
    for (int i = 0; i < q_dat.size() && i < 6; i++)
      chk($sformatf("t3_dat%0d", i), q_dat[i], e3[i]);
    s.in_valid = 1'b0;
    step();

    // Reset mid-row, then a clean row.
    set_x(17'h0, 17'h0, 17'h0);
    s.in_valid = 1'b1;
    pulse_start();
    for (int i = 0; i < 20 && u_dut.idx != 3'd3; i++) step();
    chk("t4_reach_idx3", u_dut.idx, 3);
    reset = 1'b1; s.in_valid = 1'b0;
    step();
    chk_reset("t4");
    reset = 1'b0;
    step();
    clear_mon();
    set_x(17'h0, 17'h0, 17'h0);
    s.in_valid = 1'b1;
    d0 = done_cnt;
    pulse_start();
    wait_done(40, d0);
    chk_row_alt("t4r");
    s.in_valid = 1'b0;
    step();

    // start while busy must be ignored.
    clear_mon();
    set_x(17'h0, 17'h0, 17'h0);
    s.in_valid = 1'b1;
    d0 = done_cnt;
    pulse_start();
    chk("t5_busy_run", busy, 1);
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    start = 1'b1; step(); start = 1'b0;
    wait_done(40, d0);
    repeat (8) step();
    chk("t5_done_once", done_cnt, d0 + 1);
    chk("t5_cnt", q_dat.size(), 6);
    chk("t5_idle_busy", busy, 0);
    s.in_valid = 1'b0;

    // VEC_LEN=1 instance.
    s1.in_data = 17'h00005; s1.in_valid = 1'b1; s1.out_ready = 1'b1;
    start1 = 1'b1; step(); start1 = 1'b0;
    for (int i = 0; i < 20 && !s1.out_valid; i++) step();
    chk("t6_vld",  s1.out_valid, 1);
    chk("t6_dat",  s1.out_data, 17'h07FFB);
    chk("t6_last", s1.out_last, 1);
    step();
    chk("t6_done",     done1, 1);
    chk("t6_vld_off",  s1.out_valid, 0);
    chk("t6_busy_off", busy1, 0);
    s1.in_valid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
